// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control decoder and its MD sequencer.
package alu_ctrl_pkg;

   localparam logic [2:0] AluOpAdd   = 3'b000;
   localparam logic [2:0] AluOpSub   = 3'b001;
   localparam logic [2:0] AluOpRtype = 3'b010;
   localparam logic [2:0] AluOpAnd   = 3'b011;
   localparam logic [2:0] AluOpOr    = 3'b100;
   localparam logic [2:0] AluOpSlt   = 3'b101;
   localparam logic [2:0] AluOpLui   = 3'b110;
   localparam logic [2:0] AluOpXor   = 3'b111;

   localparam logic [3:0] CtrlAnd  = 4'b0000;
   localparam logic [3:0] CtrlOr   = 4'b0001;
   localparam logic [3:0] CtrlAdd  = 4'b0010;
   localparam logic [3:0] CtrlXor  = 4'b0011;
   localparam logic [3:0] CtrlNor  = 4'b0100;
   localparam logic [3:0] CtrlSltu = 4'b0101;
   localparam logic [3:0] CtrlSub  = 4'b0110;
   localparam logic [3:0] CtrlSlt  = 4'b0111;
   localparam logic [3:0] CtrlSll  = 4'b1000;
   localparam logic [3:0] CtrlSrl  = 4'b1001;
   localparam logic [3:0] CtrlSra  = 4'b1010;
   localparam logic [3:0] CtrlLui  = 4'b1011;
   localparam logic [3:0] CtrlNop  = 4'b1111;

   localparam logic [5:0] FunctAnd  = 6'b100100;
   localparam logic [5:0] FunctOr   = 6'b100101;
   localparam logic [5:0] FunctXor  = 6'b100110;
   localparam logic [5:0] FunctNor  = 6'b100111;
   localparam logic [5:0] FunctSlt  = 6'b101010;
   localparam logic [5:0] FunctSltu = 6'b101011;
   localparam logic [5:0] FunctSll  = 6'b000000;
   localparam logic [5:0] FunctSrl  = 6'b000010;
   localparam logic [5:0] FunctSra  = 6'b000011;
   localparam logic [5:0] FunctJr   = 6'b001000;

   typedef enum logic [1:0] {
      MdMult  = 2'b00,
      MdMultu = 2'b01,
      MdDiv   = 2'b10,
      MdDivu  = 2'b11
   } md_op_e;

   typedef enum logic {
      StIdle,
      StBusy
   } state_e;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of {ALUOp, funct} into ALU control, jr, illegal and MD detect.
module alu_ctrl_dec
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W = 4
) (
   input  logic [2:0]        alu_op_i,
   input  logic [5:0]        funct_i,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   output logic              jr_o,
   output logic              illegal_o,
   output logic              is_md_o
);

   logic [3:0] code;

   always_comb begin
      code      = CtrlAdd;
      jr_o      = 1'b0;
      illegal_o = 1'b0;
      is_md_o   = 1'b0;
      unique case (alu_op_i)
         AluOpAdd: code = CtrlAdd;
         AluOpSub: code = CtrlSub;
         AluOpAnd: code = CtrlAnd;
         AluOpOr:  code = CtrlOr;
         AluOpSlt: code = CtrlSlt;
         AluOpLui: code = CtrlLui;
         AluOpXor: code = CtrlXor;
         AluOpRtype: begin
            casez (funct_i)
               6'b10000?: code = CtrlAdd;
               6'b10001?: code = CtrlSub;
               FunctAnd:  code = CtrlAnd;
               FunctOr:   code = CtrlOr;
               FunctXor:  code = CtrlXor;
               FunctNor:  code = CtrlNor;
               FunctSlt:  code = CtrlSlt;
               FunctSltu: code = CtrlSltu;
               FunctSll:  code = CtrlSll;
               FunctSrl:  code = CtrlSrl;
               FunctSra:  code = CtrlSra;
               FunctJr: begin
                  code = CtrlNop;
                  jr_o = 1'b1;
               end
               6'b0110??: begin
                  code    = CtrlNop;
                  is_md_o = 1'b1;
               end
               default: begin
                  code      = CtrlAdd;
                  illegal_o = 1'b1;
               end
            endcase
         end
         default: code = CtrlAdd;
      endcase
   end

   assign alu_ctrl_o = CTRL_W'(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with an issue handshake and a mult/div latency sequencer.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W  = 4,
   parameter int unsigned MUL_LAT = 32,
   parameter int unsigned DIV_LAT = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [2:0]        alu_op_i,
   input  logic [5:0]        funct_i,
   input  logic              flush_i,
   output logic              ctrl_valid_o,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   output logic              jr_o,
   output logic              illegal_o,
   output logic              md_start_o,
   output logic [1:0]        md_op_o,
   output logic              md_busy_o,
   output logic              md_done_o,
   output logic              stall_o
);

   localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
   localparam logic [CntW-1:0] MulLoad = CntW'(MUL_LAT - 1);
   localparam logic [CntW-1:0] DivLoad = CntW'(DIV_LAT - 1);

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic                ctrl_valid_q;
   logic [CTRL_W-1:0]   alu_ctrl_q;
   logic                jr_q;
   logic                illegal_q;
   logic                md_start_q;
   md_op_e              md_op_q;
   logic                md_busy_q;
   logic                md_done_q;

   logic [CTRL_W-1:0]   dec_ctrl;
   logic                dec_jr;
   logic                dec_illegal;
   logic                dec_is_md;
   logic                issue;

   alu_ctrl_dec #(
      .CTRL_W (CTRL_W)
   ) u_dec (
      .alu_op_i   (alu_op_i),
      .funct_i    (funct_i),
      .alu_ctrl_o (dec_ctrl),
      .jr_o       (dec_jr),
      .illegal_o  (dec_illegal),
      .is_md_o    (dec_is_md)
   );

   assign in_ready_o = (state_q == StIdle);
   assign issue      = in_valid_i & in_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         ctrl_valid_q <= 1'b0;
         alu_ctrl_q   <= CTRL_W'(CtrlAdd);
         jr_q         <= 1'b0;
         illegal_q    <= 1'b0;
         md_start_q   <= 1'b0;
         md_op_q      <= MdMult;
         md_busy_q    <= 1'b0;
         md_done_q    <= 1'b0;
      end else begin
         ctrl_valid_q <= 1'b0;
         md_start_q   <= 1'b0;
         md_done_q    <= 1'b0;
         // Flush beats both a new issue and counter expiry; decoded fields are kept.
         if (flush_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (issue) begin
                     ctrl_valid_q <= 1'b1;
                     alu_ctrl_q   <= dec_ctrl;
                     jr_q         <= dec_jr;
                     illegal_q    <= dec_illegal;
                     if (dec_is_md) begin
                        state_q    <= StBusy;
                        md_start_q <= 1'b1;
                        md_op_q    <= md_op_e'(funct_i[1:0]);
                        cnt_q      <= funct_i[1] ? DivLoad : MulLoad;
                        md_busy_q  <= 1'b1;
                     end
                  end
               end
               StBusy: begin
                  if (cnt_q == '0) begin
                     state_q   <= StIdle;
                     md_done_q <= 1'b1;
                     md_busy_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign ctrl_valid_o = ctrl_valid_q;
   assign alu_ctrl_o   = alu_ctrl_q;
   assign jr_o         = jr_q;
   assign illegal_o    = illegal_q;
   assign md_start_o   = md_start_q;
   assign md_op_o      = md_op_q;
   assign md_busy_o    = md_busy_q;
   assign md_done_o    = md_done_q;
   assign stall_o      = md_busy_q;

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Registered, parametrised successor to the single-cycle ALU control decoder, for the multi-cycle datapath. It accepts an issue handshake carrying a 3-bit ALUOp plus funct, then produces ALU control, JR detect and illegal-funct flags one cycle later. It also sequences iterative mult/div operations with a latency counter, holding off issue and stalling the pipeline until done. It sits between the main control unit and the ALU / multiply-divide unit.

Parameters:
CTRL_W, 4, width of alu_ctrl output (min 4)
MUL_LAT, 32, cycles a mult/multu occupies the MD unit (min 1)
DIV_LAT, 32, cycles a div/divu occupies the MD unit (min 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  issue request
in_ready  output  1  block can accept an issue
alu_op  input  3  ALUOp from main control
funct  input  6  instruction funct field
flush  input  1  synchronous abort of any in-flight op
ctrl_valid  output  1  one-cycle pulse: decoded outputs are valid
alu_ctrl  output  CTRL_W  ALU operation code
jr  output  1  funct is jr under R-type
illegal  output  1  R-type funct not recognised
md_start  output  1  one-cycle pulse: start MD unit
md_op  output  2  00 mult, 01 multu, 10 div, 11 divu
md_busy  output  1  MD op in flight
md_done  output  1  one-cycle pulse: MD op completed
stall  output  1  equals md_busy; holds the pipeline

Behaviour:
- Clocking and reset: single clk. rst_n low asynchronously clears all state. Reset values: state IDLE, counter 0, ctrl_valid 0, alu_ctrl 4'b0010, jr 0, illegal 0, md_start 0, md_op 0, md_busy 0, md_done 0. in_ready is combinational; it is 1 in IDLE and 0 otherwise.
- ALUOp decode:
  - 000 ADD (lw/sw/addi)
  - 001 SUB (branch)
  - 010 R-type via funct
  - 011 AND (andi)
  - 100 OR (ori)
  - 101 SLT (slti)
  - 110 LUI
  - 111 XOR (xori)
- alu_ctrl codes (zero-extended to CTRL_W): AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SLTU 0101, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, LUI 1011, NOP 1111.
- R-type funct map:
  - add/addu 10000x -> ADD; sub/subu 10001x -> SUB
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR
  - 101010 SLT; 101011 SLTU
  - 000000 SLL; 000010 SRL; 000011 SRA
  - 001000 jr -> NOP with jr=1
  - 011000..011011 -> NOP with MD start
  - any other funct -> ADD with illegal=1
- Issue: a transfer occurs when in_valid && in_ready. Outputs register on that edge, so latency is 1. ctrl_valid pulses for exactly one cycle. alu_ctrl, jr and illegal hold until the next issue. jr and illegal are 0 for non-R-type ALUOp.
- FSM:
  - IDLE --issue of MD funct--> BUSY. On that edge: md_start=1 for one cycle, md_op = funct[1:0], counter loaded with MUL_LAT-1 (funct[1]=0) or DIV_LAT-1 (funct[1]=1), md_busy=1.
  - BUSY: counter decrements each cycle. When the counter is 0, the next edge asserts md_done for one cycle, clears md_busy, and returns to IDLE.
  - Total md_busy high time is exactly MUL_LAT or DIV_LAT cycles. in_ready is 0 throughout BUSY, so a new issue is accepted on the cycle md_done is high.
  - Non-MD issue stays in IDLE.
- flush: wins over issue and over counter expiry. Next edge: state IDLE, counter 0, md_busy 0, md_start 0, ctrl_valid 0, md_done not asserted. alu_ctrl, jr and illegal retain their values.
- Counter width: $clog2(max(MUL_LAT,DIV_LAT)). With a latency of 1, the counter loads 0 and md_done fires on the following edge.
- in_valid while in_ready=0 is ignored. No buffering; upstream must hold the request.
- rst_n asserted mid-BUSY aborts immediately with no md_done.

Decomposition:
- Package alu_ctrl_pkg holds ALUOp encodings, alu_ctrl code localparams, funct constants, and the md_op enum.
- One natural sub-module, alu_ctrl_dec: purely combinational decode of {alu_op, funct} to alu_ctrl/jr/illegal/is_md. The top holds the FSM, counter and output registers.

Test Plan:
- Reset: drive rst_n low mid-cycle -> all outputs at reset values immediately, in_ready=1 after release.
- R-type sweep: alu_op=010 with each funct, e.g. 100010 -> next cycle ctrl_valid=1, alu_ctrl=0110. funct 001000 -> jr=1, alu_ctrl=1111. funct 111111 -> illegal=1, alu_ctrl=0010.
- I-type and mem: alu_op=000 -> 0010; 001 -> 0110; 110 -> 1011; 111 -> 0011; jr=0 throughout.
- Divide with DIV_LAT=4: issue 011010 -> md_start pulse with md_op=10, md_busy/stall high for 4 cycles, in_ready=0, md_done pulse. A back-to-back add issued during md_done is accepted.
- Flush: MUL_LAT=8, issue mult, assert flush in the 3rd busy cycle -> next edge md_busy=0, no md_done, in_ready=1.
- Edge latency: MUL_LAT=1, issue multu -> md_busy high exactly 1 cycle, md_done next edge. An in_valid held during busy is accepted only after in_ready returns to 1.
